dmx_tx: RTL and testbench
=========================

DMX_TX -- requirements
Module: dmx_tx

Interface
- REQ-001: Parameter BIT_CYCLES, default 200; clk cycles per DMX bit (200 = 4 us at 50 MHz); legal range 2..4095.
- REQ-002: Parameter BREAK_BITS, default 23; BREAK length in bit times (92 us).
- REQ-003: Parameter MAB_BITS, default 3; mark-after-break length in bit times (12 us).
- REQ-004: Parameter NUM_SLOTS, default 512; data slots per frame after the start code; legal range 24..512.
- REQ-005: clk  input  1  system clock; the block's only clock.
- REQ-006: reset  input  1  asynchronous, active-low reset.
- REQ-007: enable  input  1  level; 1 = transmit frames continuously, 0 = stop after the current frame.
- REQ-008: rd_addr  output  10  universe buffer read address; 0 = start code, 1..512 = slots.
- REQ-009: rd_data  input  8  buffer read data; valid exactly 1 clk after rd_addr changes.
- REQ-010: tx  output  1  serial DMX line data, registered; idle/mark = 1.
- REQ-011: tx_en  output  1  RS-485 driver enable, registered.
- REQ-012: busy  output  1  1 whenever state is not IDLE.
- REQ-013: frame_done  output  1  single-cycle pulse when a frame's last stop bit ends.

Function
- REQ-014: The state machine shall have states IDLE, BREAK, MAB, LOAD and SLOT.
- REQ-015: In IDLE, tx = 1, tx_en = 0, rd_addr = 0; enable is sampled every cycle, and enable = 1 moves the machine to BREAK on the next edge.
- REQ-016: BREAK shall drive tx = 0 and tx_en = 1 for exactly BREAK_BITS*BIT_CYCLES cycles, then move to MAB.
- REQ-017: MAB shall drive tx = 1 for exactly MAB_BITS*BIT_CYCLES cycles, then move to LOAD with slot counter = 0.
- REQ-018: LOAD shall last exactly 2 cycles with tx = 1:
  - rd_addr = slot counter during both cycles;
  - rd_data is captured into the shift register at the end of the second cycle;
  - the machine then moves to SLOT.
- REQ-019: SLOT shall shift 11 bits, each held BIT_CYCLES cycles:
  - start bit 0;
  - data[0] through data[7], LSB first;
  - two stop bits of 1.
- REQ-020: Slot 0 (the start code) shall be read from buffer address 0 like any other slot; the block shall never substitute the start code.
- REQ-021: At the end of SLOT, if slot counter < NUM_SLOTS, the counter shall increment and the machine shall return to LOAD.
- REQ-022: At the end of SLOT, if slot counter = NUM_SLOTS, frame_done shall pulse for 1 cycle and the machine shall enter IDLE.
- REQ-023: Frame length from the first BREAK cycle to the frame_done cycle shall be (BREAK_BITS+MAB_BITS)*BIT_CYCLES + (NUM_SLOTS+1)*(2+11*BIT_CYCLES) cycles.
- REQ-024: tx_en shall be 1 from the first BREAK cycle through the last stop-bit cycle and 0 in IDLE.
- REQ-025: Deasserting enable mid-frame shall not truncate the frame; the frame completes, then the machine stays in IDLE.
- REQ-026: With enable held at 1, the next BREAK shall begin on the cycle after the single IDLE cycle that follows frame_done.
- REQ-027: Bit-timing counter and bit index shall never wrap past their terminal counts; the slot counter shall be 10 bits and never exceed NUM_SLOTS.
- REQ-028: rd_data shall be ignored in every cycle except the second LOAD cycle.

Reset
- REQ-029: While reset = 0, outputs shall be tx = 1, tx_en = 0, busy = 0, frame_done = 0, rd_addr = 0, state IDLE, all counters 0.
- REQ-030: Reset asserted mid-frame shall take effect immediately without waiting for a clock edge; no frame_done shall be produced for the aborted frame.
- REQ-031: After reset is released, the first BREAK shall start no earlier than the second rising clk edge.

Verification
- REQ-032: Reset check: hold reset = 0 for 3 cycles -> tx = 1, tx_en = 0, busy = 0, rd_addr = 0, frame_done = 0.
- REQ-033: Break/MAB timing (BIT_CYCLES = 4, BREAK_BITS = 23, MAB_BITS = 3): pulse enable -> tx = 0 for exactly 92 cycles, then tx = 1 for 12 MAB cycles plus 2 LOAD cycles.
- REQ-034: Slot waveform (buf[0] = 0x00, buf[1] = 0xA5):
  - slot 0 -> 0, 0,0,0,0,0,0,0,0, 1,1;
  - slot 1 -> 0, 1,0,1,0,0,1,0,1, 1,1;
  - each bit exactly 4 cycles.
- REQ-035: Frame length (NUM_SLOTS = 24, BIT_CYCLES = 4):
  - frame_done exactly 1254 cycles after the first BREAK cycle;
  - rd_addr visits 0..24 in ascending order, once each.
- REQ-036: Enable handling:
  - enable held at 1 -> second BREAK starts 2 cycles after frame_done;
  - enable dropped in slot 5 -> frame completes and IDLE persists with tx = 1.
- REQ-037: Reset asserted during slot 3 -> tx = 1 and tx_en = 0 before the next clk edge; no frame_done pulse; IDLE after release.

Source files
------------

// File: rtl/dmx_tx.sv
// DMX512 frame transmitter: BREAK, mark-after-break, then start code plus
// NUM_SLOTS data slots fetched one at a time from an external universe buffer.
module dmx_tx #(
  parameter int BIT_CYCLES = 200,
  parameter int BREAK_BITS = 23,
  parameter int MAB_BITS   = 3,
  parameter int NUM_SLOTS  = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       tx,
  output logic       tx_en,
  output logic       busy,
  output logic       frame_done
);

  localparam int MAX_BITS = (BREAK_BITS > MAB_BITS) ? ((BREAK_BITS > 11) ? BREAK_BITS : 11)
                                                    : ((MAB_BITS > 11) ? MAB_BITS : 11);
  localparam int BIT_W = $clog2(MAX_BITS + 1);

  localparam logic [11:0]      CYC_LAST  = 12'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BRK_LAST  = BIT_W'(BREAK_BITS - 1);
  localparam logic [BIT_W-1:0] MAB_LAST  = BIT_W'(MAB_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(10);
  localparam logic [BIT_W-1:0] BIT_ZERO  = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [9:0]       SLOT_MAX  = 10'(NUM_SLOTS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BREAK = 3'd1,
    S_MAB   = 3'd2,
    S_LOAD  = 3'd3,
    S_SLOT  = 3'd4
  } state_t;

  state_t           state_r;
  logic [11:0]      cyc_r;
  logic [BIT_W-1:0] bit_r;
  logic [9:0]       slot_r;
  logic [10:0]      shift_r;
  logic [9:0]       rd_addr_r;
  logic             tx_r;
  logic             tx_en_r;
  logic             busy_r;
  logic             frame_done_r;
  logic             started_r;
  logic             cyc_end_s;
  logic             go_s;

  assign cyc_end_s = (cyc_r == CYC_LAST);
  // started_r delays the first BREAK after reset; frame_done_r forces one idle gap cycle
  assign go_s      = enable & started_r & ~frame_done_r;

  assign rd_addr    = rd_addr_r;
  assign tx         = tx_r;
  assign tx_en      = tx_en_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  // Frame sequencer; line outputs are registered alongside each state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      cyc_r        <= 12'd0;
      bit_r        <= BIT_ZERO;
      slot_r       <= 10'd0;
      shift_r      <= 11'h7FF;
      rd_addr_r    <= 10'd0;
      tx_r         <= 1'b1;
      tx_en_r      <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      started_r    <= 1'b0;
    end else begin
      started_r    <= 1'b1;
      frame_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          cyc_r     <= 12'd0;
          bit_r     <= BIT_ZERO;
          slot_r    <= 10'd0;
          rd_addr_r <= 10'd0;
          if (go_s) begin
            state_r <= S_BREAK;
            tx_r    <= 1'b0;
            tx_en_r <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            tx_r    <= 1'b1;
            tx_en_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        S_BREAK: begin
          if (cyc_end_s) begin
            cyc_r <= 12'd0;
            if (bit_r == BRK_LAST) begin
              bit_r   <= BIT_ZERO;
              state_r <= S_MAB;
              tx_r    <= 1'b1;
            end else begin
              bit_r <= bit_r + BIT_ONE;
            end
          end else begin
            cyc_r <= cyc_r + 12'd1;
          end
        end
        S_MAB: begin
          if (cyc_end_s) begin
            cyc_r <= 12'd0;
            if (bit_r == MAB_LAST) begin
              bit_r     <= BIT_ZERO;
              slot_r    <= 10'd0;
              rd_addr_r <= 10'd0;
              state_r   <= S_LOAD;
            end else begin
              bit_r <= bit_r + BIT_ONE;
            end
          end else begin
            cyc_r <= cyc_r + 12'd1;
          end
        end
        S_LOAD: begin
          // rd_data is valid in the second cycle, one clock after rd_addr settled
          if (cyc_r == 12'd0) begin
            cyc_r <= 12'd1;
          end else begin
            cyc_r   <= 12'd0;
            bit_r   <= BIT_ZERO;
            shift_r <= {2'b11, rd_data, 1'b0};
            tx_r    <= 1'b0;
            state_r <= S_SLOT;
          end
        end
        S_SLOT: begin
          if (cyc_end_s) begin
            cyc_r <= 12'd0;
            if (bit_r == SLOT_LAST) begin
              bit_r <= BIT_ZERO;
              tx_r  <= 1'b1;
              if (slot_r == SLOT_MAX) begin
                state_r      <= S_IDLE;
                slot_r       <= 10'd0;
                rd_addr_r    <= 10'd0;
                tx_en_r      <= 1'b0;
                busy_r       <= 1'b0;
                frame_done_r <= 1'b1;
              end else begin
                slot_r    <= slot_r + 10'd1;
                rd_addr_r <= slot_r + 10'd1;
                state_r   <= S_LOAD;
              end
            end else begin
              bit_r   <= bit_r + BIT_ONE;
              shift_r <= {1'b1, shift_r[10:1]};
              tx_r    <= shift_r[1];
            end
          end else begin
            cyc_r <= cyc_r + 12'd1;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          cyc_r     <= 12'd0;
          bit_r     <= BIT_ZERO;
          slot_r    <= 10'd0;
          rd_addr_r <= 10'd0;
          tx_r      <= 1'b1;
          tx_en_r   <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmx_tx.sv
// Directed bench for dmx_tx: per-cycle expected tx/rd_addr scoreboard, enable
// handling, start-after-reset delay and mid-frame asynchronous reset.
module tb_dmx_tx;

  localparam int BC     = 4;
  localparam int BRK    = 23;
  localparam int MAB    = 3;
  localparam int NSLOTS = 24;
  localparam int FRAME_LEN = (BRK + MAB) * BC + (NSLOTS + 1) * (2 + 11 * BC);

  typedef struct packed {
    logic       tx;
    logic [9:0] addr;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       tx;
  logic       tx_en;
  logic       busy;
  logic       frame_done;

  logic [7:0] mem [0:1023];
  exp_t       exp_q [$];
  int         tests;
  int         failed;

  dmx_tx #(
    .BIT_CYCLES(BC),
    .BREAK_BITS(BRK),
    .MAB_BITS  (MAB),
    .NUM_SLOTS (NSLOTS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tx        (tx),
    .tx_en     (tx_en),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous buffer model: data follows the address by one clock
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    logic [10:0] fr;
    for (int i = 0; i < BRK * BC; i++) begin
      e.tx = 1'b0; e.addr = 10'd0; exp_q.push_back(e);
    end
    for (int i = 0; i < MAB * BC; i++) begin
      e.tx = 1'b1; e.addr = 10'd0; exp_q.push_back(e);
    end
    for (int s = 0; s <= NSLOTS; s++) begin
      e.tx = 1'b1; e.addr = 10'(s);
      exp_q.push_back(e);
      exp_q.push_back(e);
      fr = {2'b11, mem[s], 1'b0};
      for (int b = 0; b < 11; b++) begin
        for (int c = 0; c < BC; c++) begin
          e.tx = fr[b]; e.addr = 10'(s); exp_q.push_back(e);
        end
      end
    end
  endtask

  // Called at the negedge of the first BREAK cycle; returns at the frame_done cycle
  task automatic check_frame(input int drop_at);
    exp_t e;
    for (int t = 0; t < FRAME_LEN; t++) begin
      if (t == drop_at) enable = 1'b0;
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("tx@%0d", t), 32'(tx), 32'(e.tx));
        check($sformatf("rd_addr@%0d", t), 32'(rd_addr), 32'(e.addr));
      end
      check($sformatf("tx_en@%0d", t), 32'(tx_en), 32'd1);
      check($sformatf("frame_done_early@%0d", t), 32'(frame_done), 32'd0);
      @(negedge clk);
    end
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    check("done_tx_en", 32'(tx_en), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_tx", 32'(tx), 32'd1);
    check("done_rd_addr", 32'(rd_addr), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_busy(input int limit, output int n);
    n = 0;
    while (!busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("start_timeout", 32'(busy), 32'd1);
  endtask

  initial begin
    int n;
    tests  = 0;
    failed = 0;
    reset  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h00;
    mem[1] = 8'hA5;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // Frame 1: enable present at release; BREAK no earlier than second edge
    reset  = 1'b1;
    enable = 1'b1;
    wait_busy(10, n);
    check("start_delay_ge2", 32'(n >= 2), 32'd1);
    check("break_tx_first", 32'(tx), 32'd0);
    push_frame();
    check_frame(-1);

    // Frame 2 with new contents, nonzero start code; enable held -> BREAK 2 cycles later
    for (int i = 0; i <= NSLOTS; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h17;
    @(negedge clk);
    check("gap_busy", 32'(busy), 32'd0);
    check("gap_tx", 32'(tx), 32'd1);
    check("gap_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    check("rebreak_busy", 32'(busy), 32'd1);
    check("rebreak_tx", 32'(tx), 32'd0);
    push_frame();
    // drop enable inside slot 5
    check_frame((BRK + MAB) * BC + 5 * (2 + 11 * BC) + 6);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_busy%0d", i), 32'(busy), 32'd0);
      check($sformatf("idle_tx%0d", i), 32'(tx), 32'd1);
      check($sformatf("idle_tx_en%0d", i), 32'(tx_en), 32'd0);
    end

    // Frame 3 aborted by reset during slot 3
    enable = 1'b1;
    wait_busy(5, n);
    check("f3_start_delay", 32'(n), 32'd1);
    repeat ((BRK + MAB) * BC + 3 * (2 + 11 * BC) + 10) @(negedge clk);
    check("f3_in_slot3_addr", 32'(rd_addr), 32'd3);
    check("f3_in_slot3_tx_en", 32'(tx_en), 32'd1);
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_tx_en", 32'(tx_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_addr", 32'(rd_addr), 32'd0);
    check("abort_frame_done", 32'(frame_done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_done", 32'(frame_done), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("post_busy%0d", i), 32'(busy), 32'd0);
      check($sformatf("post_done%0d", i), 32'(frame_done), 32'd0);
      check($sformatf("post_tx%0d", i), 32'(tx), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
